i2s_frame_tx: RTL and testbench

//  Master-mode I2S transmitter: divides Clock into BCLK/LRCK, serialises one stereo sample pair per frame on SDATA.

---
 rtl/i2s_frame_tx_pkg.sv | 19 +
 rtl/i2s_frame_tx_bclk_divider.sv | 49 ++++
 rtl/i2s_frame_tx.sv | 160 ++++++++++++++++
 tb/tb_i2s_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_frame_tx_pkg.sv
// Shared types and defaults for the I2S frame transmitter.
package i2s_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_SAMPLE_W = 16;
  localparam int unsigned DEF_SLOT_W   = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_frame_tx_bclk_divider.sv
// Bit-clock divider: counts CLK_DIV cycles per BCLK half-period and flags BCLK falling edges.
module i2s_frame_tx_bclk_divider
  import i2s_frame_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall_c
);

  localparam int unsigned      DIV_W    = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;

  // Count while enabled, toggle BCLK on wrap; cleared to zero while disabled.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!en) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk   = bclk_q;
  assign fall_c = en && bclk_q && (div_q == DIV_LAST);

endmodule

// File: rtl/i2s_frame_tx.sv
// Master-mode I2S transmitter: BCLK/LRCK generation, one-pair buffer, serialiser, frame strobe.
module i2s_frame_tx
  import i2s_frame_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned SLOT_W   = DEF_SLOT_W
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [SAMPLE_W-1:0] InLeft,
  input  logic [SAMPLE_W-1:0] InRight,
  input  logic                InValid,
  output logic                InReady,
  output logic                BCLK,
  output logic                LRCK,
  output logic                SDATA,
  output logic                Frame,
  output logic                Underrun,
  output logic                Busy
);

  localparam int unsigned      BIT_W    = cnt_w(2 * SLOT_W);
  localparam int unsigned      PAIR_W   = 2 * SAMPLE_W;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(SAMPLE_W);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_W + 1);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_W + SAMPLE_W);
  localparam logic [BIT_W-1:0] LR_SPLIT = BIT_W'(SLOT_W);

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    b_q, b_d;
  logic                lrck_q, lrck_d;
  logic                sdata_q, sdata_d;
  logic                frame_q, frame_d;
  logic                underrun_q, underrun_d;
  logic                busy_q, busy_d;
  logic                buf_empty_q, buf_empty_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_W-1:0] buf_r_q, buf_r_d;
  logic [PAIR_W-1:0]   shreg_q, shreg_d;
  logic                fall_c;
  logic                wrap_c;

  i2s_frame_tx_bclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (Clock),
    .rst   (Reset),
    .en    (state_q != ST_IDLE),
    .bclk  (BCLK),
    .fall_c(fall_c)
  );

  assign wrap_c = fall_c && (b_q == BIT_LAST);

  // Run-state FSM; frame and underrun strobes are decided one cycle ahead so they land in the frame-start cycle.
  always_comb begin
    state_d    = state_q;
    frame_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d = ST_RUN;
          frame_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (wrap_c) begin
          if (Enable) frame_d = 1'b1;
          else        state_d = ST_IDLE;
        end else if (!Enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (Enable) begin
          state_d = ST_RUN;
          frame_d = wrap_c;
        end else if (wrap_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    underrun_d = frame_d && buf_empty_d;
  end

  // Buffer hand-off in the frame-start cycle, sample capture, bit index and serialiser.
  always_comb begin
    buf_empty_d = buf_empty_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    shreg_d     = shreg_q;
    sdata_d     = sdata_q;
    b_d         = b_q;
    if (frame_q) begin
      shreg_d     = buf_empty_q ? '0 : {buf_l_q, buf_r_q};
      buf_empty_d = 1'b1;
    end
    if (InValid && buf_empty_q) begin
      buf_l_d     = InLeft;
      buf_r_d     = InRight;
      buf_empty_d = 1'b0;
    end
    if (state_q == ST_IDLE) begin
      b_d     = '0;
      sdata_d = 1'b0;
    end else if (fall_c) begin
      b_d = (b_q == BIT_LAST) ? '0 : b_q + BIT_W'(1);
      if (((b_d >= L_FIRST) && (b_d <= L_LAST)) || ((b_d >= R_FIRST) && (b_d <= R_LAST))) begin
        sdata_d = shreg_q[PAIR_W-1];
        shreg_d = {shreg_q[PAIR_W-2:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end
    lrck_d = (b_d >= LR_SPLIT);
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      buf_empty_q <= 1'b1;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      buf_empty_q <= buf_empty_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      shreg_q     <= shreg_d;
    end
  end

  assign InReady  = buf_empty_q;
  assign LRCK     = lrck_q;
  assign SDATA    = sdata_q;
  assign Frame    = frame_q;
  assign Underrun = underrun_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Self-checking bench for i2s_frame_tx: frame-position model plus directed literal checks.
module tb_i2s_frame_tx;

  localparam int CD        = 2;
  localparam int SW        = 16;
  localparam int SL        = 32;
  localparam int FRAME_CYC = 2 * SL * 2 * CD;

  logic          Clock   = 1'b0;
  logic          Reset   = 1'b0;
  logic          Enable  = 1'b0;
  logic          InValid = 1'b0;
  logic [SW-1:0] InLeft  = '0;
  logic [SW-1:0] InRight = '0;
  logic          InReady, BCLK, LRCK, SDATA, Frame, Underrun, Busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_on = 1'b0;

  // Model: whether the frame clock runs, the cycle position inside the frame, buffer and current frame data.
  bit            m_active   = 1'b0;
  int            m_ph       = 0;
  bit            m_buf_full = 1'b0;
  logic [SW-1:0] m_buf_l = '0, m_buf_r = '0;
  logic [SW-1:0] m_cur_l = '0, m_cur_r = '0;

  i2s_frame_tx #(
    .CLK_DIV (CD),
    .SAMPLE_W(SW),
    .SLOT_W  (SL)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .InLeft  (InLeft),
    .InRight (InRight),
    .InValid (InValid),
    .InReady (InReady),
    .BCLK    (BCLK),
    .LRCK    (LRCK),
    .SDATA   (SDATA),
    .Frame   (Frame),
    .Underrun(Underrun),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Serial bit at frame position ph: one-bit delay after each slot boundary, MSB first, zero elsewhere.
  function automatic logic exp_sdata(input int ph, input logic [SW-1:0] l, input logic [SW-1:0] r);
    int            b;
    logic [SW-1:0] t;
    b = ph / (2 * CD);
    if (b >= 1 && b <= SW) begin
      t = l >> (SW - b);
      return t[0];
    end
    if (b >= SL + 1 && b <= SL + SW) begin
      t = r >> (SL + SW - b);
      return t[0];
    end
    return 1'b0;
  endfunction

  // Model update at each clock: frame hand-off, buffer capture, frame position.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_active   <= 1'b0;
      m_ph       <= 0;
      m_buf_full <= 1'b0;
      m_cur_l    <= '0;
      m_cur_r    <= '0;
    end else begin
      if (m_active && m_ph == 0) begin
        m_cur_l <= m_buf_full ? m_buf_l : '0;
        m_cur_r <= m_buf_full ? m_buf_r : '0;
      end
      if (InValid && !m_buf_full) begin
        m_buf_l    <= InLeft;
        m_buf_r    <= InRight;
        m_buf_full <= 1'b1;
      end else if (m_active && m_ph == 0) begin
        m_buf_full <= 1'b0;
      end
      if (!m_active || m_ph == FRAME_CYC - 1) begin
        m_active <= Enable;
        m_ph     <= 0;
      end else begin
        m_ph <= m_ph + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clock) begin
    if (cmp_on && !Reset) begin
      check1("cmp_bclk", BCLK, m_active && ((m_ph / CD) % 2 == 1));
      check1("cmp_lrck", LRCK, m_active && (m_ph / (2 * CD) >= SL));
      check1("cmp_sdata", SDATA, m_active && exp_sdata(m_ph, m_cur_l, m_cur_r));
      check1("cmp_frame", Frame, m_active && m_ph == 0);
      check1("cmp_underrun", Underrun, m_active && m_ph == 0 && !m_buf_full);
      check1("cmp_busy", Busy, m_active);
      check1("cmp_inready", InReady, !m_buf_full);
    end
  end

  task automatic wait_frame(input string name, output int t);
    bit found;
    found = 1'b0;
    t     = cyc;
    for (int i = 0; i < 2 * FRAME_CYC + 8; i++) begin
      @(negedge Clock);
      if (Frame === 1'b1) begin
        found = 1'b1;
        t     = cyc;
        break;
      end
    end
    if (!found) checkn(name, 0, 1);
  endtask

  task automatic goto_ph(input int t, input int ph);
    while (cyc < t + ph) @(negedge Clock);
  endtask

  task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n;
    n = 0;
    while (InReady !== 1'b1 && n < 2 * FRAME_CYC) begin
      @(negedge Clock);
      n++;
    end
    check1("send_ready", InReady, 1'b1);
    InLeft  = l;
    InRight = r;
    InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
  endtask

  int t0, t1, t2, t3, t4, t5, t6, te;
  int frames, accepts, nframes;
  bit pending, chk_next;

  initial begin
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check1("rst_bclk", BCLK, 1'b0);
    check1("rst_lrck", LRCK, 1'b0);
    check1("rst_sdata", SDATA, 1'b0);
    check1("rst_frame", Frame, 1'b0);
    check1("rst_underrun", Underrun, 1'b0);
    check1("rst_busy", Busy, 1'b0);
    check1("rst_inready", InReady, 1'b1);
    #2 Reset = 1'b0;
    cmp_on = 1'b1;
    @(negedge Clock);

    // 1: pair buffered in IDLE, then run
    send_pair(16'hA5C3, 16'h0F0F);
    check1("t1_buffer_full", InReady, 1'b0);
    Enable = 1'b1;
    te = cyc;
    wait_frame("t1_frame_timeout", t0);
    checkn("t1_first_frame_latency", t0 - te, 1);
    check1("t1_no_underrun", Underrun, 1'b0);
    goto_ph(t0, 5);   check1("t1_l_msb", SDATA, 1'b1);
    goto_ph(t0, 9);   check1("t1_l_bit14", SDATA, 1'b0);
    goto_ph(t0, 125); check1("t1_lrck_b31", LRCK, 1'b0);
    goto_ph(t0, 129); check1("t1_lrck_b32", LRCK, 1'b1);
    goto_ph(t0, 133); check1("t1_r_msb", SDATA, 1'b0);
    goto_ph(t0, 149); check1("t1_r_bit11", SDATA, 1'b1);

    // 2: no data -> underrun frame
    wait_frame("t2_frame_timeout", t1);
    checkn("t2_period", t1 - t0, FRAME_CYC);
    check1("t2_underrun", Underrun, 1'b1);
    goto_ph(t1, 5);   check1("t2_zero_data", SDATA, 1'b0);

    // 3: pair offered in the frame-start cycle goes to the next frame
    wait_frame("t3_frame_timeout", t2);
    check1("t3_underrun", Underrun, 1'b1);
    check1("t3_ready_on_frame", InReady, 1'b1);
    InLeft = 16'h8001; InRight = 16'hC000; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    check1("t3_stored", InReady, 1'b0);
    goto_ph(t2, 5);   check1("t3_frame_zero", SDATA, 1'b0);
    wait_frame("t3b_frame_timeout", t3);
    checkn("t3_period", t3 - t2, FRAME_CYC);
    check1("t3b_no_underrun", Underrun, 1'b0);
    goto_ph(t3, 5);   check1("t3b_l_msb", SDATA, 1'b1);
    goto_ph(t3, 9);   check1("t3b_l_bit14", SDATA, 1'b0);
    goto_ph(t3, 65);  check1("t3b_l_lsb", SDATA, 1'b1);
    goto_ph(t3, 133); check1("t3b_r_msb", SDATA, 1'b1);
    goto_ph(t3, 141); check1("t3b_r_bit13", SDATA, 1'b0);

    // 6: InValid held high -> one pair accepted per frame
    InLeft = 16'h1111; InRight = 16'h2222; InValid = 1'b1;
    frames = 0; accepts = 0; pending = 1'b0; chk_next = 1'b0;
    for (int i = 0; i < 4 * FRAME_CYC + 16 && frames < 4; i++) begin
      if (pending) begin
        InLeft  = InLeft + 16'h1357;
        InRight = ~InLeft;
        pending = 1'b0;
      end
      if (chk_next) begin
        check1("t6_ready_after_frame", InReady, 1'b1);
        chk_next = 1'b0;
      end
      if (Frame === 1'b1) begin
        if (frames > 0) checkn("t6_accepts_per_frame", accepts, 1);
        check1("t6_full_on_frame", InReady, 1'b0);
        accepts  = 0;
        frames++;
        chk_next = 1'b1;
      end
      if (InReady === 1'b1) begin
        accepts++;
        pending = 1'b1;
      end
      @(negedge Clock);
    end
    InValid = 1'b0;
    checkn("t6_frames_seen", frames, 4);

    // 4: Enable dropped at b=10 -> frame completes, then idle
    wait_frame("t4_frame_timeout", t4);
    goto_ph(t4, 40);
    Enable = 1'b0;
    goto_ph(t4, FRAME_CYC - 1); check1("t4_busy_last", Busy, 1'b1);
    goto_ph(t4, FRAME_CYC);
    check1("t4_busy_fall", Busy, 1'b0);
    check1("t4_no_frame", Frame, 1'b0);
    check1("t4_bclk_rest", BCLK, 1'b0);
    check1("t4_lrck_rest", LRCK, 1'b0);
    nframes = 0;
    repeat (600) begin
      @(negedge Clock);
      if (Frame === 1'b1) nframes++;
    end
    checkn("t4_frames_while_idle", nframes, 0);

    // 5: asynchronous reset at b=40 discards the buffered pair
    Enable = 1'b1;
    wait_frame("t5_frame_timeout", t5);
    send_pair(16'h0246, 16'h8ACE);
    goto_ph(t5, 163);
    check1("t5_lrck_before", LRCK, 1'b1);
    check1("t5_bclk_before", BCLK, 1'b1);
    #2 Reset = 1'b1;
    Enable = 1'b0;
    #1;
    check1("t5_async_bclk", BCLK, 1'b0);
    check1("t5_async_lrck", LRCK, 1'b0);
    check1("t5_async_busy", Busy, 1'b0);
    check1("t5_async_inready", InReady, 1'b1);
    @(negedge Clock);
    #2 Reset = 1'b0;
    @(negedge Clock);
    Enable = 1'b1;
    @(negedge Clock);
    check1("t5_frame_first_run", Frame, 1'b1);
    check1("t5_underrun_discarded", Underrun, 1'b1);
    check1("t5_busy", Busy, 1'b1);
    t6 = cyc;
    wait_frame("t5b_frame_timeout", t5);
    checkn("t5_period", t5 - t6, FRAME_CYC);
    repeat (20) @(negedge Clock);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
